// File: rtl/dmem_arb_pkg.sv
// Shared state encoding, widths and the address-legality check for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MEM_BYTES_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // One captured access: who owns it, what it does, and whether it is illegal.
  typedef struct packed {
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              err;
  } txn_t;

  // Word accesses only, and the whole word must fit inside the memory.
  function automatic logic addr_reject(input logic [ADDR_W-1:0] addr,
                                       input int unsigned       mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > ADDR_W'(mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick, purely combinational; contention goes to the side not granted last.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two requesters: gnt in T, memory strobe in T+1, done in T+2.
// Requests wait (held by the requester) while the FSM is busy; one access per 3 cycles at most.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_done_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_done_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_t            state_q, state_d;
  logic [1:0]        req;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt;
  logic              last_q;
  txn_t              txn_q, txn_new;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [DATA_W-1:0] rd_val;

  assign req = {m1_req_i, m0_req_i};

  rr_arbiter_2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Grants only leave the block while idle and out of reset.
  always_comb begin
    gnt = 2'b00;
    if ((state_q == IDLE) && !rst_i) gnt = arb_gnt;
  end

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  always_comb begin
    txn_new       = '0;
    txn_new.owner = gnt[1];
    if (gnt[1]) begin
      txn_new.we    = m1_we_i;
      txn_new.addr  = m1_addr_i;
      txn_new.wdata = m1_wdata_i;
    end else begin
      txn_new.we    = m0_we_i;
      txn_new.addr  = m0_addr_i;
      txn_new.wdata = m0_wdata_i;
    end
    txn_new.err = addr_reject(txn_new.addr, MEM_BYTES);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Strobes depend only on state, so a write in flight when reset hits still lands.
  always_comb begin
    state_d     = state_q;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = DONE;
        if (!txn_q.err) begin
          mem_read_o  = !txn_q.we;
          mem_write_o = txn_q.we;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr_o = txn_q.addr;
  assign mem_data_o = txn_q.wdata;
  assign rd_val     = txn_q.err ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q   <= 1'b1;
      txn_q    <= '0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      if (gnt != 2'b00) begin
        last_q <= gnt[1];
        txn_q  <= txn_new;
      end
      if (state_q == ACCESS) begin
        done_q[txn_q.owner] <= 1'b1;
        err_q[txn_q.owner]  <= txn_q.err;
        // Writes leave the owner's last read data untouched; rejects report zero.
        if (txn_q.err || !txn_q.we) begin
          if (txn_q.owner) rdata1_q <= rd_val;
          else             rdata0_q <= rd_val;
        end
      end
    end
  end

  assign m0_done_o  = done_q[0];
  assign m1_done_o  = done_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  localparam int MB = 128;
  localparam int NW = MB / 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_v, we_v;
  logic [31:0] addr_v [2];
  logic [31:0] wd_v [2];
  logic        m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_rdata_i;
  logic        mem_read_o, mem_write_o;

  // Environment memory (combinational read, write at the clock edge).
  logic [31:0] mem_w  [NW];
  logic [31:0] init_w [NW];
  logic        mem_init_done;

  // Reference model state.
  logic [31:0] ref_w [NW];
  int          cyc, free_at, last_w, g_cyc;
  bit          inflight;
  int          t_own;
  bit          t_we, t_err;
  logic [31:0] t_addr, t_wd, t_rd;
  logic [31:0] hold [2];
  logic [31:0] last_rd [2];
  bit          last_err [2];
  int          glog_who[$];
  int          glog_cyc[$];
  int          strobe_cnt;
  int          n_total, n_pass, n_fail;

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem_w[mem_addr_o[6:2]];

  always @(posedge clk_i) begin
    if (!mem_init_done) begin
      for (int i = 0; i < NW; i++) mem_w[i] <= init_w[i];
    end else if (mem_write_o) begin
      mem_w[mem_addr_o[6:2]] <= mem_data_o;
    end
  end

  dmem_arbiter #(.MEM_BYTES(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(req_v[0]), .m0_we_i(we_v[0]), .m0_addr_i(addr_v[0]), .m0_wdata_i(wd_v[0]),
    .m0_gnt_o(m0_gnt_o), .m0_done_o(m0_done_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(req_v[1]), .m1_we_i(we_v[1]), .m1_addr_i(addr_v[1]), .m1_wdata_i(wd_v[1]),
    .m1_gnt_o(m1_gnt_o), .m1_done_o(m1_done_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int n, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_v[n]  = 1'b1;
    we_v[n]   = w;
    addr_v[n] = a;
    wd_v[n]   = d;
  endtask

  // Called just after a rising edge with this cycle's inputs already driven.
  task automatic run_cycle();
    logic [1:0] exp_g, obs_g, exp_d;
    int w;
    w = 0;
    #1;
    obs_g = {m1_gnt_o, m0_gnt_o};
    exp_g = 2'b00;
    if (!rst_i && cyc >= free_at && req_v != 2'b00) begin
      if (req_v == 2'b11) w = 1 - last_w;
      else                w = req_v[1] ? 1 : 0;
      exp_g[w] = 1'b1;
    end
    chk("gnt", 32'(obs_g), 32'(exp_g));

    if (inflight && cyc == g_cyc + 1) begin
      chk("mem_read", 32'(mem_read_o), 32'(!t_we && !t_err));
      chk("mem_write", 32'(mem_write_o), 32'(t_we && !t_err));
      if (!t_err) begin
        chk("mem_addr", mem_addr_o, t_addr);
        if (t_we) begin
          chk("mem_data", mem_data_o, t_wd);
          ref_w[t_addr[6:2]] = t_wd;
        end
      end
    end else begin
      chk("strobe_idle", 32'({mem_read_o, mem_write_o}), 32'd0);
    end
    if (mem_read_o || mem_write_o) strobe_cnt++;

    exp_d = 2'b00;
    if (inflight && cyc == g_cyc + 2) begin
      exp_d[t_own] = 1'b1;
      if (t_err || !t_we) hold[t_own] = t_rd;
    end
    chk("done", 32'({m1_done_o, m0_done_o}), 32'(exp_d));
    chk("err", 32'({m1_err_o, m0_err_o}), 32'(t_err ? exp_d : 2'b00));
    chk("rdata0", m0_rdata_o, hold[0]);
    chk("rdata1", m1_rdata_o, hold[1]);
    if (exp_d != 2'b00) begin
      last_rd[t_own]  = (t_own == 1) ? m1_rdata_o : m0_rdata_o;
      last_err[t_own] = (t_own == 1) ? m1_err_o : m0_err_o;
      inflight = 1'b0;
    end

    if (exp_g != 2'b00) begin
      inflight = 1'b1;
      g_cyc    = cyc;
      t_own    = w;
      t_we     = we_v[w];
      t_addr   = addr_v[w];
      t_wd     = wd_v[w];
      t_err    = (t_addr[1:0] != 2'b00) || (t_addr > 32'(MB - 4));
      t_rd     = t_err ? 32'd0 : ref_w[t_addr[6:2]];
      free_at  = cyc + 3;
      last_w   = w;
      glog_who.push_back(w);
      glog_cyc.push_back(cyc);
    end
    if (rst_i) begin
      inflight = 1'b0;
      last_w   = 1;
      free_at  = cyc + 1;
      hold[0]  = 32'd0;
      hold[1]  = 32'd0;
    end

    @(posedge clk_i);
    #1;
    cyc++;
    for (int n = 0; n < 2; n++) if (obs_g[n]) req_v[n] = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while ((req_v != 2'b00 || inflight) && k < maxc) begin
      run_cycle();
      k++;
    end
    chk("idle_timeout", 32'(req_v != 2'b00 || inflight), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'($urandom_range(0, 160));
    return 32'($urandom_range(0, NW - 1) * 4);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s;
    rst_i = 1'b1;
    req_v = 2'b00;
    we_v  = 2'b00;
    for (int n = 0; n < 2; n++) begin
      addr_v[n] = '0; wd_v[n] = '0; hold[n] = '0; last_rd[n] = '0; last_err[n] = 1'b0;
    end
    mem_init_done = 1'b0;
    for (int i = 0; i < NW; i++) init_w[i] = $urandom;
    init_w[0] = 32'h0000_0003;
    init_w[1] = 32'h0000_0001;
    init_w[2] = 32'hEEF6_F798;
    for (int i = 0; i < NW; i++) ref_w[i] = init_w[i];
    n_total = 0; n_pass = 0; n_fail = 0; strobe_cnt = 0;

    repeat (2) @(posedge clk_i);
    #1;
    mem_init_done = 1'b1;
    chk("rst_mem_read", 32'(mem_read_o), 32'd0);
    chk("rst_mem_write", 32'(mem_write_o), 32'd0);
    chk("rst_done", 32'({m1_done_o, m0_done_o}), 32'd0);
    chk("rst_err", 32'({m1_err_o, m0_err_o}), 32'd0);
    chk("rst_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_rdata0", m0_rdata_o, 32'd0);
    chk("rst_rdata1", m1_rdata_o, 32'd0);
    rst_i = 1'b0;
    cyc = 0; free_at = 0; last_w = 1; inflight = 1'b0; g_cyc = 0;
    t_own = 0; t_we = 1'b0; t_err = 1'b0; t_addr = '0; t_wd = '0; t_rd = '0;

    // Single read of word 0.
    issue(0, 1'b0, 32'd0, 32'd0);
    wait_idle(10);
    chk("s1_rdata", last_rd[0], 32'h0000_0003);

    // Both read across a reset: no grant during reset, m0 wins first after it.
    issue(0, 1'b0, 32'd8, 32'd0);
    issue(1, 1'b0, 32'd4, 32'd0);
    rst_i = 1'b1;
    run_cycle();
    rst_i = 1'b0;
    base = glog_who.size();
    wait_idle(12);
    chk("s2_first", 32'(glog_who[base]), 32'd0);
    chk("s2_rdata0", last_rd[0], 32'hEEF6_F798);
    chk("s2_rdata1", last_rd[1], 32'h0000_0001);

    // Continuous contention alternates every 3 cycles.
    base = glog_who.size();
    for (int k = 0; k < 14; k++) begin
      for (int n = 0; n < 2; n++) if (!req_v[n]) issue(n, 1'b0, rand_addr(), 32'd0);
      run_cycle();
    end
    wait_idle(12);
    chk("s3_count", 32'(glog_who.size() >= base + 4), 32'd1);
    if (glog_who.size() >= base + 4) begin
      chk("s3_start", 32'(glog_who[base]), 32'd0);
      for (int i = 1; i < 4; i++) begin
        chk("s3_alt", 32'(glog_who[base + i]), 32'(i % 2));
        chk("s3_period", 32'(glog_cyc[base + i] - glog_cyc[base + i - 1]), 32'd3);
      end
    end

    // Write by m1 seen by a read from m0.
    issue(1, 1'b1, 32'd60, 32'hDEAD_BEEF);
    wait_idle(10);
    issue(0, 1'b0, 32'd60, 32'd0);
    wait_idle(10);
    chk("s4_rdata", last_rd[0], 32'hDEAD_BEEF);

    // Misaligned read and out-of-range write are both rejected without strobes.
    s = strobe_cnt;
    issue(0, 1'b0, 32'd6, 32'd0);
    issue(1, 1'b1, 32'd128, 32'h1234_5678);
    wait_idle(12);
    chk("s5_no_strobe", 32'(strobe_cnt - s), 32'd0);
    chk("s5_err0", 32'(last_err[0]), 32'd1);
    chk("s5_err1", 32'(last_err[1]), 32'd1);
    chk("s5_rdata0", last_rd[0], 32'd0);
    chk("s5_rdata1", last_rd[1], 32'd0);

    // Reset during a write's ACCESS cycle: write lands, no done, m0 wins next.
    issue(0, 1'b1, 32'd20, 32'hCAFE_F00D);
    base = glog_who.size();
    for (int k = 0; k < 6 && glog_who.size() == base; k++) run_cycle();
    chk("s6_granted", 32'(glog_who.size() - base), 32'd1);
    rst_i = 1'b1;
    run_cycle();
    rst_i = 1'b0;
    issue(0, 1'b0, 32'd20, 32'd0);
    issue(1, 1'b0, 32'd24, 32'd0);
    base = glog_who.size();
    wait_idle(12);
    chk("s6_first", 32'(glog_who[base]), 32'd0);
    chk("s6_rdata", last_rd[0], 32'hCAFE_F00D);

    // Random mixed traffic.
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++)
        if (!req_v[n] && $urandom_range(0, 1) == 1)
          issue(n, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      run_cycle();
    end
    wait_idle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
